// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM address and
// captures fetched words into the IF/ID register under start/halt/stall/redirect control.
module instr_fetch #(
   parameter int unsigned          ADDR_W    = 8,
   parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
   parameter logic [31:0]          HALT_WORD = 32'h0000_000C
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus1,
   output logic              halted,
   output logic [15:0]       fetch_cnt
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;

   assign rom_addr    = pc;
   assign if_pc_plus1 = if_pc + ADDR_W'(1);

   // Fetch FSM with the PC, IF/ID register and debug counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         if_valid  <= 1'b0;
         if_instr  <= '0;
         if_pc     <= '0;
         fetch_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            IDLE, HALT: begin
               // The halt word stays visible until the first unstalled edge.
               if (state == IDLE || !stall) begin
                  if_valid <= 1'b0;
               end
               if (redirect_valid) begin
                  pc <= redirect_addr;
               end else if (start && state == HALT) begin
                  pc <= pc + ADDR_W'(1);
               end
               if (start) begin
                  state  <= RUN;
                  halted <= 1'b0;
               end
            end
            RUN: begin
               if (redirect_valid) begin
                  pc       <= redirect_addr;
                  if_valid <= 1'b0;
               end else if (!stall) begin
                  if_instr <= rom_data;
                  if_pc    <= pc;
                  if_valid <= 1'b1;
                  if (fetch_cnt != {CNT_W{1'b1}}) begin
                     fetch_cnt <= fetch_cnt + CNT_W'(1);
                  end
                  if (rom_data == HALT_WORD) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     pc <= pc + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state  <= IDLE;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a behavioural ROM.
module tb_instr_fetch;

   localparam int unsigned ADDR_W = 8;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              stall;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              if_valid;
   logic [31:0]       if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic [ADDR_W-1:0] if_pc_plus1;
   logic              halted;
   logic [15:0]       fetch_cnt;

   logic [31:0] rom [256];
   int checks = 0;
   int errors = 0;

   assign rom_data = rom[rom_addr];

   instr_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus1    (if_pc_plus1),
      .halted         (halted),
      .fetch_cnt      (fetch_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic v, input logic [ADDR_W-1:0] a);
      redirect_valid = v;
      redirect_addr  = a;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stall = 1'b0;
      redir(1'b0, 8'd0);
      for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 + 32'(i);
      rom[7] = 32'h0000_000C;

      // reset values
      #8;
      check("rst_valid", 32'(if_valid), 32'd0);
      check("rst_instr", if_instr, 32'd0);
      check("rst_pc", 32'(if_pc), 32'd0);
      check("rst_cnt", 32'(fetch_cnt), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_romaddr", 32'(rom_addr), 32'd0);
      #4 rst_n = 1'b1;

      // start, sequential fetch 0..7, halt on word 7
      start = 1'b1;
      step();
      check("start_valid", 32'(if_valid), 32'd0);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("seq_pc", 32'(if_pc), 32'(i));
         check("seq_instr", if_instr, rom[i]);
         check("seq_valid", 32'(if_valid), 32'd1);
         check("seq_cnt", 32'(fetch_cnt), 32'(i + 1));
      end
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_romaddr", 32'(rom_addr), 32'd7);
      step();
      check("halt_valid", 32'(if_valid), 32'd0);
      check("halt_hold", 32'(halted), 32'd1);
      check("halt_cnt", 32'(fetch_cnt), 32'd8);

      // restart from 0 via start+redirect, then stall while if_pc=2
      start = 1'b1;
      redir(1'b1, 8'd0);
      step();
      start = 1'b0;
      redir(1'b0, 8'd0);
      check("rs_romaddr", 32'(rom_addr), 32'd0);
      check("rs_halted", 32'(halted), 32'd0);
      check("rs_valid", 32'(if_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rs_pc", 32'(if_pc), 32'(i));
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", 32'(if_pc), 32'd2);
         check("stall_instr", if_instr, rom[2]);
         check("stall_cnt", 32'(fetch_cnt), 32'd11);
      end
      stall = 1'b0;
      step();
      check("unstall_pc", 32'(if_pc), 32'd3);
      check("unstall_cnt", 32'(fetch_cnt), 32'd12);

      // redirect to 5 while PC=2 with stall high
      redir(1'b1, 8'd1);
      step();
      redir(1'b0, 8'd0);
      step();
      check("pre_pc", 32'(if_pc), 32'd1);
      check("pre_romaddr", 32'(rom_addr), 32'd2);
      redir(1'b1, 8'd5);
      stall = 1'b1;
      step();
      redir(1'b0, 8'd0);
      stall = 1'b0;
      check("rd_bubble", 32'(if_valid), 32'd0);
      check("rd_romaddr", 32'(rom_addr), 32'd5);
      check("rd_cnt", 32'(fetch_cnt), 32'd13);
      step();
      check("rd_pc", 32'(if_pc), 32'd5);
      check("rd_instr", if_instr, rom[5]);
      check("rd_valid", 32'(if_valid), 32'd1);
      check("rd_cnt2", 32'(fetch_cnt), 32'd14);

      // wrap-around 254,255,0,1
      rom[7] = 32'h1000_0007;
      redir(1'b1, 8'd254);
      step();
      redir(1'b0, 8'd0);
      step();
      check("wr_pc0", 32'(if_pc), 32'd254);
      check("wr_p1_0", 32'(if_pc_plus1), 32'd255);
      step();
      check("wr_pc1", 32'(if_pc), 32'd255);
      check("wr_instr1", if_instr, rom[255]);
      check("wr_p1_1", 32'(if_pc_plus1), 32'd0);
      step();
      check("wr_pc2", 32'(if_pc), 32'd0);
      step();
      check("wr_pc3", 32'(if_pc), 32'd1);
      check("wr_cnt", 32'(fetch_cnt), 32'd18);

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(if_valid), 32'd0);
      check("ar_pc", 32'(if_pc), 32'd0);
      check("ar_instr", if_instr, 32'd0);
      check("ar_cnt", 32'(fetch_cnt), 32'd0);
      check("ar_romaddr", 32'(rom_addr), 32'd0);
      #1 rst_n = 1'b1;
      step();
      step();
      check("idle_valid", 32'(if_valid), 32'd0);
      check("idle_romaddr", 32'(rom_addr), 32'd0);

      // redirect alone in IDLE presets the PC only
      redir(1'b1, 8'd9);
      step();
      redir(1'b0, 8'd0);
      step();
      check("idle_preset", 32'(rom_addr), 32'd9);
      check("idle_valid2", 32'(if_valid), 32'd0);

      // start with redirect to 3 in IDLE, then halt at 5 and resume
      rom[5] = 32'h0000_000C;
      start = 1'b1;
      redir(1'b1, 8'd3);
      step();
      start = 1'b0;
      redir(1'b0, 8'd0);
      check("sr_romaddr", 32'(rom_addr), 32'd3);
      step();
      check("sr_pc", 32'(if_pc), 32'd3);
      check("sr_valid", 32'(if_valid), 32'd1);
      check("sr_cnt", 32'(fetch_cnt), 32'd1);
      step();
      step();
      check("h2_pc", 32'(if_pc), 32'd5);
      check("h2_halted", 32'(halted), 32'd1);
      stall = 1'b1;
      step();
      check("h2_stall_valid", 32'(if_valid), 32'd1);
      check("h2_stall_pc", 32'(if_pc), 32'd5);
      stall = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("h2_resume_valid", 32'(if_valid), 32'd0);
      check("h2_resume_halted", 32'(halted), 32'd0);
      check("h2_resume_romaddr", 32'(rom_addr), 32'd6);
      check("h2_resume_cnt", 32'(fetch_cnt), 32'd3);
      step();
      check("h2_next_pc", 32'(if_pc), 32'd6);
      check("h2_next_valid", 32'(if_valid), 32'd1);
      check("h2_next_cnt", 32'(fetch_cnt), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle/pipelined MIPS core. The block owns the program counter and drives the word address of the combinational instruction ROM (8-bit address, 32-bit data). It captures the returned word into the IF/ID register with its PC and a valid flag. It also supports start/halt control, stall, redirect (branch/jump flush) and a saturating fetch counter for debug.

## Interface
- `ADDR_W`, 8: PC / ROM word-address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `HALT_WORD`, 32'h0000_000C: instruction encoding (`syscall`) that halts fetch.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  level sampled each edge; leaves IDLE/HALT.
- `stall`  in  1  downstream hold request; freezes PC and IF/ID register.
- `redirect_valid`  in  1  branch/jump taken; load new PC and flush.
- `redirect_addr`  in  ADDR_W  redirect target word address.
- `rom_addr`  out  ADDR_W  ROM address, combinationally equal to the PC register.
- `rom_data`  in  32  ROM read data, valid in the same cycle as `rom_addr`.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a live instruction.
- `if_instr`  out  32  fetched instruction.
- `if_pc`  out  ADDR_W  address of `if_instr`.
- `if_pc_plus1`  out  ADDR_W  `if_pc + 1` mod 2^ADDR_W, combinational from `if_pc`.
- `halted`  out  1  high while in HALT.
- `fetch_cnt`  out  16  number of instructions latched valid, saturating.

## Operation
- FSM states: IDLE, RUN, HALT. Reset puts the FSM in IDLE.
- IDLE:
  - No fetch takes place; `if_valid` is held at 0.
  - `start`=1 moves to RUN. PC is unchanged.
- RUN, normal edge (no redirect, no stall):
  - `if_instr`<=`rom_data`, `if_pc`<=PC, `if_valid`<=1.
  - PC<=PC+1; wraps 255->0.
  - `fetch_cnt`<=`fetch_cnt`+1, saturating at 0xFFFF.
- RUN, halt word fetched (`rom_data`==`HALT_WORD`):
  - The word is latched exactly as in a normal edge (valid, counted).
  - PC is not incremented. The FSM moves to HALT.
- RUN, `stall`=1, no redirect:
  - PC, `if_*`, `fetch_cnt` and the FSM state all hold.
  - Halt detection is suppressed.
- `redirect_valid`=1, any state:
  - PC<=`redirect_addr`.
  - In RUN: `if_valid`<=0, no count increment, no halt detection, and the FSM stays in RUN.
  - Redirect has priority over `stall` and over halt detection.
  - In IDLE/HALT: only the PC is loaded (used to preset the start address); the state is unchanged.
- HALT:
  - `halted`=1.
  - On the first edge with `stall`=0, `if_valid`<=0, so the halt word is handed downstream once.
  - `start`=1 (no redirect): PC<=PC+1 and the FSM moves to RUN.
- When `start` and `redirect_valid` coincide in IDLE/HALT: the PC takes `redirect_addr` (no +1) and the FSM moves to RUN.

## Timing
- Reset values:
  - PC=`RESET_PC`, state=IDLE.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `fetch_cnt`=0, `halted`=0.
  - `rom_addr`=`RESET_PC`.
- Fetch latency: PC=A at edge n in RUN gives `if_instr`=ROM[A], `if_pc`=A, `if_valid`=1 after edge n.
- Throughput: one instruction per cycle while unstalled.
- Start latency: `start` sampled at edge n; the first valid instruction appears after edge n+1.
- Redirect latency:
  - Target address T is on `rom_addr` after edge n.
  - ROM[T] is valid after edge n+1.
  - Exactly one bubble (`if_valid`=0) results.
- `rom_addr` and `if_pc_plus1` are combinational; every other output is registered.
- `halted` rises in the cycle after the halt word is latched.
- Asserting `rst_n` low mid-operation immediately forces all reset values, with no wait for a clock edge. After release the FSM restarts in IDLE.

## Test plan
- Reset then `start`, ROM words 0..6 non-halt, word 7 = 0x0000000C:
  - Expect `if_pc` 0,1,...,7 on consecutive cycles with the matching words.
  - Expect `halted`=1 after the 0x0000000C capture and `fetch_cnt`=8.
  - Expect `if_valid`=0 afterwards.
- Stall for 3 cycles while `if_pc`=2:
  - `if_pc`/`if_instr` stay at 2 / ROM[2] and `fetch_cnt` is frozen.
  - The next unstalled edge gives `if_pc`=3.
- Redirect to 5 while PC=2, with `stall` also high:
  - Expect one `if_valid`=0 cycle, then `if_pc`=5 and `if_instr`=ROM[5]; the PC skips 2..4.
- Wrap-around: redirect to 254 with no halt words in the ROM.
  - Expect `if_pc` sequence 254, 255, 0, 1.
  - Expect `if_pc_plus1`=0 while `if_pc`=255.
- In IDLE, redirect to 3 together with `start`: the first valid output is `if_pc`=3.
- Mid-run `rst_n` pulse between clock edges:
  - Outputs clear asynchronously, PC=0, state IDLE.
  - No fetch occurs until the next `start`.
